// File: rtl/srl_pkg.sv
// Shared types and constants for the word-to-serial transmitter.
package srl_pkg;

    localparam int SRL_DEFAULT_WIDTH = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        GAP   = 2'd2
    } srl_state_t;

endpackage

// File: rtl/srl_hold_buf.sv
// One-entry hold register in front of the shifter, with a registered ready.
module srl_hold_buf #(
    parameter int WIDTH = srl_pkg::SRL_DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    input  logic             take,
    output logic             in_ready,
    output logic             hold_full,
    output logic [WIDTH-1:0] hold_data
);
    import srl_pkg::*;

    logic rdy_q;
    logic accept;
    logic full_nxt;

    assign accept = in_valid && rdy_q;

    // A new word wins over a same-edge transfer, so the entry stays occupied.
    always_comb begin
        full_nxt = hold_full;
        if (take)
            full_nxt = 1'b0;
        if (accept)
            full_nxt = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hold_full <= 1'b0;
            rdy_q     <= 1'b0;
        end else begin
            hold_full <= full_nxt;
            rdy_q     <= !full_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (accept)
            hold_data <= in_data;
    end

    assign in_ready = rdy_q && !rst;

endmodule

// File: rtl/srl_word_tx.sv
// Serializes parallel words MSB first with optional idle cycles between frames.
module srl_word_tx #(
    parameter int WIDTH = srl_pkg::SRL_DEFAULT_WIDTH,
    parameter int GAP   = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    output logic             srl_out,
    output logic             srl_valid,
    output logic             frame_start,
    output logic             frame_end,
    output logic             busy
);
    import srl_pkg::*;

    localparam int               CNT_W    = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
    localparam logic [3:0]       GAP_LOAD = (GAP > 0) ? 4'(GAP - 1) : 4'd0;

    srl_state_t       state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic [3:0]       gap_cnt, gap_cnt_nxt;
    logic [WIDTH-1:0] shifter, shifter_nxt;
    logic             hold_full;
    logic [WIDTH-1:0] hold_data;
    logic             take;

    srl_hold_buf #(.WIDTH(WIDTH)) u_hold (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_data  (in_data),
        .take     (take),
        .in_ready (in_ready),
        .hold_full(hold_full),
        .hold_data(hold_data)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            cnt     <= '0;
            gap_cnt <= '0;
            shifter <= '0;
        end else begin
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            gap_cnt <= gap_cnt_nxt;
            shifter <= shifter_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt;
        gap_cnt_nxt = gap_cnt;
        shifter_nxt = shifter;
        take        = 1'b0;
        unique case (state)
            IDLE: begin
                if (hold_full)
                    take = 1'b1;
            end
            SHIFT: begin
                shifter_nxt = {shifter[WIDTH-2:0], 1'b0};
                cnt_nxt     = cnt + 1'b1;
                if (cnt == CNT_LAST) begin
                    cnt_nxt = '0;
                    if (GAP > 0) begin
                        state_nxt   = srl_pkg::GAP;
                        gap_cnt_nxt = GAP_LOAD;
                    end else if (hold_full) begin
                        take = 1'b1;
                    end else begin
                        state_nxt = IDLE;
                    end
                end
            end
            srl_pkg::GAP: begin
                if (gap_cnt == 4'd0) begin
                    if (hold_full)
                        take = 1'b1;
                    else
                        state_nxt = IDLE;
                end else begin
                    gap_cnt_nxt = gap_cnt - 4'd1;
                end
            end
            default: state_nxt = IDLE;
        endcase
        // Any transfer from hold restarts a frame, whatever state it came from.
        if (take) begin
            state_nxt   = SHIFT;
            shifter_nxt = hold_data;
            cnt_nxt     = '0;
        end
    end

    assign srl_valid   = (state == SHIFT) && !rst;
    assign srl_out     = srl_valid && shifter[WIDTH-1];
    assign frame_start = srl_valid && (cnt == '0);
    assign frame_end   = srl_valid && (cnt == CNT_LAST);
    assign busy        = !rst && ((state != IDLE) || hold_full);

endmodule

// File: tb/tb_srl_word_tx.sv
// Bench for srl_word_tx: a 32-bit/no-gap and an 8-bit/gap-3 instance share one stimulus stream.
module tb_srl_word_tx;

    localparam int WA = 32;
    localparam int GA = 0;
    localparam int WB = 8;
    localparam int GB = 3;
    localparam int NF = 2048;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic [31:0] in_data = '0;

    logic a_ready, a_out, a_valid, a_fs, a_fe, a_busy;
    logic b_ready, b_out, b_valid, b_fs, b_fe, b_busy;

    always #5 clk = ~clk;

    srl_word_tx #(.WIDTH(WA), .GAP(GA)) dut_a (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
        .in_ready(a_ready), .srl_out(a_out), .srl_valid(a_valid),
        .frame_start(a_fs), .frame_end(a_fe), .busy(a_busy)
    );

    srl_word_tx #(.WIDTH(WB), .GAP(GB)) dut_b (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data[7:0]),
        .in_ready(b_ready), .srl_out(b_out), .srl_valid(b_valid),
        .frame_start(b_fs), .frame_end(b_fe), .busy(b_busy)
    );

    int vectors = 0;
    int miscompares = 0;

    // Reference model: each accepted word becomes a scheduled frame.
    // start = max(previous end + GAP + 1, accept cycle + 2); the word sits in
    // hold from the cycle after acceptance until the cycle before its start.
    int          t = 0;
    int          nf[2] = '{0, 0};
    int          base[2] = '{0, 0};
    int          last_end[2] = '{-1000, -1000};
    bit          rst_prev[2] = '{1'b1, 1'b1};
    int          f_acc[2][NF];
    int          f_start[2][NF];
    logic [31:0] f_word[2][NF];

    function automatic int wid(input int i);
        return (i == 0) ? WA : WB;
    endfunction

    function automatic int gapv(input int i);
        return (i == 0) ? GA : GB;
    endfunction

    function automatic bit m_hold(input int i);
        for (int k = base[i]; k < nf[i]; k++)
            if (t >= f_acc[i][k] + 1 && t <= f_start[i][k] - 1)
                return 1'b1;
        return 1'b0;
    endfunction

    // {in_ready, srl_valid, srl_out, frame_start, frame_end, busy}
    function automatic logic [5:0] m_out(input int i, input logic r);
        logic [5:0] o;
        bit         hf;
        int         s, e;
        o = '0;
        if (r)
            return o;
        hf   = m_hold(i);
        o[5] = !rst_prev[i] && !hf;
        o[0] = hf;
        for (int k = base[i]; k < nf[i]; k++) begin
            s = f_start[i][k];
            e = s + wid(i) - 1;
            if (t >= s && t <= e) begin
                o[4] = 1'b1;
                o[3] = f_word[i][k][wid(i) - 1 - (t - s)];
                o[2] = (t == s);
                o[1] = (t == e);
            end
            if (t >= s && t <= e + gapv(i))
                o[0] = 1'b1;
        end
        return o;
    endfunction

    function automatic void m_step(input int i, input logic r, input logic v, input logic [31:0] d);
        int s;
        if (r) begin
            base[i]     = nf[i];
            last_end[i] = -1000;
        end else if (v && !rst_prev[i] && !m_hold(i) && nf[i] < NF) begin
            s = last_end[i] + gapv(i) + 1;
            if (t + 2 > s)
                s = t + 2;
            f_acc[i][nf[i]]   = t;
            f_start[i][nf[i]] = s;
            f_word[i][nf[i]]  = (i == 0) ? d : {24'b0, d[7:0]};
            nf[i]             = nf[i] + 1;
            last_end[i]       = s + wid(i) - 1;
        end
        rst_prev[i] = r;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic cycle(input logic r, input logic v, input logic [31:0] d,
                         output logic [5:0] oa, output logic [5:0] ob);
        rst      = r;
        in_valid = v;
        in_data  = d;
        #1;
        oa = {a_ready, a_valid, a_out, a_fs, a_fe, a_busy};
        ob = {b_ready, b_valid, b_out, b_fs, b_fe, b_busy};
        check($sformatf("dut_a cycle %0d outputs", t), {58'b0, oa}, {58'b0, m_out(0, r)});
        check($sformatf("dut_b cycle %0d outputs", t), {58'b0, ob}, {58'b0, m_out(1, r)});
        m_step(0, r, v, d);
        m_step(1, r, v, d);
        t++;
        @(negedge clk);
    endtask

    typedef struct {
        logic       r;
        logic       v;
        logic [7:0] d;
        logic [5:0] e;
    } vec_t;

    function automatic vec_t mk(input logic r, input logic v, input logic [7:0] d, input logic [5:0] e);
        vec_t x;
        x.r = r; x.v = v; x.d = d; x.e = e;
        return x;
    endfunction

    vec_t        tbl[28];
    logic [5:0]  oa, ob;
    logic [31:0] bits, rxw;
    logic [31:0] words[8];
    logic [31:0] rx[8];
    int          nb, first, n0, sent, run, maxrun, fe_cnt, nrx, nvld;
    int          fe_pos[4];

    initial begin
        // dut_b (8 bits, gap 3): reset, 0xA5 then 0x3C queued behind it.
        tbl[0]  = mk(1, 0, 8'h00, 6'b000000);
        tbl[1]  = mk(1, 0, 8'h00, 6'b000000);
        tbl[2]  = mk(0, 1, 8'hA5, 6'b000000);
        tbl[3]  = mk(0, 1, 8'hA5, 6'b100000);
        tbl[4]  = mk(0, 1, 8'h3C, 6'b000001);
        tbl[5]  = mk(0, 1, 8'h3C, 6'b111101);
        tbl[6]  = mk(0, 0, 8'h00, 6'b010001);
        tbl[7]  = mk(0, 0, 8'h00, 6'b011001);
        tbl[8]  = mk(0, 0, 8'h00, 6'b010001);
        tbl[9]  = mk(0, 0, 8'h00, 6'b010001);
        tbl[10] = mk(0, 0, 8'h00, 6'b011001);
        tbl[11] = mk(0, 0, 8'h00, 6'b010001);
        tbl[12] = mk(0, 0, 8'h00, 6'b011011);
        tbl[13] = mk(0, 0, 8'h00, 6'b000001);
        tbl[14] = mk(0, 0, 8'h00, 6'b000001);
        tbl[15] = mk(0, 0, 8'h00, 6'b000001);
        tbl[16] = mk(0, 0, 8'h00, 6'b110101);
        tbl[17] = mk(0, 0, 8'h00, 6'b110001);
        tbl[18] = mk(0, 0, 8'h00, 6'b111001);
        tbl[19] = mk(0, 0, 8'h00, 6'b111001);
        tbl[20] = mk(0, 0, 8'h00, 6'b111001);
        tbl[21] = mk(0, 0, 8'h00, 6'b111001);
        tbl[22] = mk(0, 0, 8'h00, 6'b110001);
        tbl[23] = mk(0, 0, 8'h00, 6'b110011);
        tbl[24] = mk(0, 0, 8'h00, 6'b100001);
        tbl[25] = mk(0, 0, 8'h00, 6'b100001);
        tbl[26] = mk(0, 0, 8'h00, 6'b100001);
        tbl[27] = mk(0, 0, 8'h00, 6'b100000);

        @(negedge clk);
        for (int j = 0; j < 28; j++) begin
            cycle(tbl[j].r, tbl[j].v, {24'b0, tbl[j].d}, oa, ob);
            check($sformatf("table row %0d dut_b", j), {58'b0, ob}, {58'b0, tbl[j].e});
        end
        for (int j = 0; j < 80; j++) cycle(0, 0, 0, oa, ob);

        // Single word from idle on the 32-bit instance.
        cycle(0, 1, 32'hA500_0001, oa, ob);
        bits = '0; nb = 0; first = -1;
        for (int j = 1; j <= 40; j++) begin
            cycle(0, 0, 0, oa, ob);
            if (oa[4]) begin
                if (nb == 0) first = j;
                bits = {bits[30:0], oa[3]};
                nb++;
            end
        end
        check("single first-bit latency", 64'(first), 64'd2);
        check("single bit count", 64'(nb), 64'd32);
        check("single serial word", {32'b0, bits}, 64'hA500_0001);
        check("single busy after frame", {63'b0, oa[0]}, 64'd0);

        // Back-to-back all-ones then all-zeros with in_valid held.
        n0 = nf[0]; run = 0; maxrun = 0; fe_cnt = 0;
        for (int j = 0; j < 120; j++) begin
            sent = nf[0] - n0;
            cycle(0, sent < 2, (sent == 0) ? 32'hFFFF_FFFF : 32'h0, oa, ob);
            if (oa[4]) begin
                if (oa[1] && fe_cnt < 4) begin
                    fe_pos[fe_cnt] = run;
                    fe_cnt++;
                end
                run++;
                if (run > maxrun) maxrun = run;
            end else begin
                run = 0;
            end
        end
        check("b2b run length", 64'(maxrun), 64'd64);
        check("b2b frame_end count", 64'(fe_cnt), 64'd2);
        check("b2b first frame_end", 64'(fe_pos[0]), 64'd31);
        check("b2b second frame_end", 64'(fe_pos[1]), 64'd63);

        // Eight random words under continuous in_valid.
        for (int k = 0; k < 8; k++) words[k] = $urandom;
        n0 = nf[0]; nb = 0; nrx = 0; rxw = '0;
        for (int j = 0; j < 400; j++) begin
            sent = nf[0] - n0;
            cycle(0, sent < 8, (sent < 8) ? words[sent[2:0]] : 32'h0, oa, ob);
            if (oa[4]) begin
                rxw = {rxw[30:0], oa[3]};
                nb++;
                if (nb == 32) begin
                    if (nrx < 8) rx[nrx] = rxw;
                    nrx++;
                    nb = 0;
                end
            end
        end
        check("stream word count", 64'(nrx), 64'd8);
        for (int k = 0; k < 8; k++)
            check($sformatf("stream word %0d", k), {32'b0, rx[k]}, {32'b0, words[k]});

        // Reset at bit 10 of a frame with a second word held.
        for (int j = 0; j < 60; j++) cycle(0, 0, 0, oa, ob);
        cycle(0, 1, 32'h1234_5678, oa, ob);
        cycle(0, 1, 32'hDEAD_BEEF, oa, ob);
        cycle(0, 1, 32'hDEAD_BEEF, oa, ob);
        for (int j = 3; j <= 11; j++) cycle(0, 0, 0, oa, ob);
        check("frame active before reset", {62'b0, oa[4], oa[0]}, 64'd3);
        cycle(1, 0, 0, oa, ob);
        check("outputs during reset", {58'b0, oa}, 64'd0);
        cycle(0, 0, 0, oa, ob);
        check("ready right after release", {58'b0, oa}, 64'd0);
        cycle(0, 0, 0, oa, ob);
        check("ready one cycle after release", {58'b0, oa}, 64'b100000);
        nvld = 0;
        for (int j = 0; j < 60; j++) begin
            cycle(0, 0, 0, oa, ob);
            if (oa[4]) nvld++;
        end
        check("no stale bits after reset", 64'(nvld), 64'd0);

        // Randomized traffic with occasional resets.
        for (int j = 0; j < 3000; j++)
            cycle($urandom_range(0, 499) == 0, $urandom_range(0, 3) != 0, $urandom, oa, ob);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
